// File: rtl/paint_mixer_if.sv
// Configuration bus of the paint mixer: per-layer register writes plus the
// pending flag that reports a write still waiting for the next frame start.
interface paint_mixer_if #(
    parameter int CIDX_ADDRW = 8
);
    logic                  cfg_we;
    logic [2:0]            cfg_layer;
    logic                  cfg_en;
    logic                  cfg_transp;
    logic [CIDX_ADDRW-1:0] cfg_base;
    logic                  cfg_pending;

    modport master (
        output cfg_we, cfg_layer, cfg_en, cfg_transp, cfg_base,
        input  cfg_pending
    );

    modport slave (
        input  cfg_we, cfg_layer, cfg_en, cfg_transp, cfg_base,
        output cfg_pending
    );
endinterface

// File: rtl/paint_mixer.sv
// N-layer paint compositor: picks the front-most visible layer, drives the CLUT
// address and realigns the display timing with the CLUT colour output.
module paint_mixer #(
    parameter int              BPC        = 5,
    parameter int              CORDW      = 16,
    parameter int              LAYERS     = 2,
    parameter int              CIDXW      = 4,
    parameter int              CIDX_ADDRW = 8,
    parameter int              CLUT_LAT   = 2,
    parameter logic [3*BPC-1:0] BG_COLR   = '0
) (
    input  logic                       clk_pix,
    input  logic                       rst_pix,
    input  logic signed [CORDW-1:0]    dx,
    input  logic signed [CORDW-1:0]    dy,
    input  logic                       hsync,
    input  logic                       vsync,
    input  logic                       de,
    input  logic                       frame_start,
    input  logic [LAYERS*CIDXW-1:0]    layer_pix,
    input  logic [LAYERS-1:0]          layer_paint,
    paint_mixer_if.slave               cfg,
    output logic [CIDX_ADDRW-1:0]      clut_addr,
    input  logic [3*BPC-1:0]           clut_dout,
    output logic signed [CORDW-1:0]    disp_x,
    output logic signed [CORDW-1:0]    disp_y,
    output logic                       disp_hsync,
    output logic                       disp_vsync,
    output logic                       disp_de,
    output logic                       disp_frame,
    output logic [BPC-1:0]             disp_r,
    output logic [BPC-1:0]             disp_g,
    output logic [BPC-1:0]             disp_b
);

    localparam int STAGES = CLUT_LAT + 1;

    typedef struct packed {
        logic signed [CORDW-1:0] x;
        logic signed [CORDW-1:0] y;
        logic                    hs;
        logic                    vs;
        logic                    de;
        logic                    frame;
    } disp_t;

    typedef struct packed {
        disp_t t;
        logic  paint;
    } timing_t;

    logic [LAYERS-1:0]                 pend_en_q, pend_en_d;
    logic [LAYERS-1:0]                 pend_tr_q, pend_tr_d;
    logic [LAYERS-1:0][CIDX_ADDRW-1:0] pend_base_q, pend_base_d;
    logic [LAYERS-1:0]                 act_en_q, act_en_d;
    logic [LAYERS-1:0]                 act_tr_q, act_tr_d;
    logic [LAYERS-1:0][CIDX_ADDRW-1:0] act_base_q, act_base_d;
    logic                              cfg_pending_q, cfg_pending_d;

    logic                              sel_paint;
    logic [CIDX_ADDRW-1:0]             clut_addr_q, clut_addr_d;
    timing_t [STAGES-1:0]              pipe_q, pipe_d;
    disp_t                             disp_q, disp_d;
    logic [3*BPC-1:0]                  rgb_q, rgb_d;

    // A write coinciding with frame_start is folded into pending first, so it
    // reaches the active set on that same edge.
    always_comb begin
        pend_en_d     = pend_en_q;
        pend_tr_d     = pend_tr_q;
        pend_base_d   = pend_base_q;
        cfg_pending_d = cfg_pending_q;
        for (int i = 0; i < LAYERS; i++) begin
            if (cfg.cfg_we && (cfg.cfg_layer == 3'(i))) begin
                pend_en_d[i]   = cfg.cfg_en;
                pend_tr_d[i]   = cfg.cfg_transp;
                pend_base_d[i] = cfg.cfg_base;
                cfg_pending_d  = 1'b1;
            end
        end
        act_en_d   = act_en_q;
        act_tr_d   = act_tr_q;
        act_base_d = act_base_q;
        if (frame_start) begin
            act_en_d      = pend_en_d;
            act_tr_d      = pend_tr_d;
            act_base_d    = pend_base_d;
            cfg_pending_d = 1'b0;
        end
    end

    // Scanning back-to-front lets the lowest-numbered visible layer win.
    always_comb begin
        logic [CIDXW-1:0] pix;
        pix         = '0;
        sel_paint   = 1'b0;
        clut_addr_d = '0;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            pix = layer_pix[i*CIDXW +: CIDXW];
            if (layer_paint[i] && act_en_d[i] && !(act_tr_d[i] && (pix == '0))) begin
                sel_paint   = 1'b1;
                clut_addr_d = act_base_d[i] + CIDX_ADDRW'(pix);
            end
        end
    end

    always_comb begin
        pipe_d[0].t.x     = dx;
        pipe_d[0].t.y     = dy;
        pipe_d[0].t.hs    = hsync;
        pipe_d[0].t.vs    = vsync;
        pipe_d[0].t.de    = de;
        pipe_d[0].t.frame = frame_start;
        pipe_d[0].paint   = sel_paint;
        for (int k = 1; k < STAGES; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
        disp_d = pipe_q[STAGES-1].t;
        rgb_d  = '0;
        if (pipe_q[STAGES-1].t.de) begin
            rgb_d = pipe_q[STAGES-1].paint ? clut_dout : BG_COLR;
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            pend_en_q     <= LAYERS'(1);
            pend_tr_q     <= '0;
            pend_base_q   <= '0;
            act_en_q      <= LAYERS'(1);
            act_tr_q      <= '0;
            act_base_q    <= '0;
            cfg_pending_q <= 1'b0;
            clut_addr_q   <= '0;
            pipe_q        <= '0;
            disp_q        <= '0;
            rgb_q         <= '0;
        end else begin
            pend_en_q     <= pend_en_d;
            pend_tr_q     <= pend_tr_d;
            pend_base_q   <= pend_base_d;
            act_en_q      <= act_en_d;
            act_tr_q      <= act_tr_d;
            act_base_q    <= act_base_d;
            cfg_pending_q <= cfg_pending_d;
            clut_addr_q   <= clut_addr_d;
            pipe_q        <= pipe_d;
            disp_q        <= disp_d;
            rgb_q         <= rgb_d;
        end
    end

    assign cfg.cfg_pending = cfg_pending_q;
    assign clut_addr       = clut_addr_q;
    assign disp_x          = disp_q.x;
    assign disp_y          = disp_q.y;
    assign disp_hsync      = disp_q.hs;
    assign disp_vsync      = disp_q.vs;
    assign disp_de         = disp_q.de;
    assign disp_frame      = disp_q.frame;
    assign disp_r          = rgb_q[3*BPC-1 -: BPC];
    assign disp_g          = rgb_q[2*BPC-1 -: BPC];
    assign disp_b          = rgb_q[BPC-1:0];

endmodule

// File: tb/tb_paint_mixer.sv
// Directed bench for paint_mixer: an identity CLUT (addr N -> colour N) with
// two cycles of latency, checked with immediate assertions.
module tb_paint_mixer;

    localparam int          BPC        = 5;
    localparam int          CORDW      = 16;
    localparam int          LAYERS     = 2;
    localparam int          CIDXW      = 4;
    localparam int          CIDX_ADDRW = 8;
    localparam int          CLUT_LAT   = 2;
    localparam logic [14:0] BG         = 15'h1234;

    logic                    clk_pix = 1'b0;
    logic                    rst_pix = 1'b0;
    logic signed [CORDW-1:0] dx = '0;
    logic signed [CORDW-1:0] dy = '0;
    logic                    hsync = 1'b0;
    logic                    vsync = 1'b0;
    logic                    de = 1'b0;
    logic                    frame_start = 1'b0;
    logic [LAYERS*CIDXW-1:0] layer_pix = '0;
    logic [LAYERS-1:0]       layer_paint = '0;
    logic [CIDX_ADDRW-1:0]   clut_addr;
    logic [3*BPC-1:0]        clut_dout;
    logic signed [CORDW-1:0] disp_x;
    logic signed [CORDW-1:0] disp_y;
    logic                    disp_hsync;
    logic                    disp_vsync;
    logic                    disp_de;
    logic                    disp_frame;
    logic [BPC-1:0]          disp_r;
    logic [BPC-1:0]          disp_g;
    logic [BPC-1:0]          disp_b;
    logic [14:0]             rgb;
    logic [7:0]              clut_d1 = '0;
    logic [7:0]              clut_d2 = '0;

    int compared   = 0;
    int mismatched = 0;

    paint_mixer_if #(.CIDX_ADDRW(CIDX_ADDRW)) cfg_bus ();

    paint_mixer #(
        .BPC(BPC), .CORDW(CORDW), .LAYERS(LAYERS), .CIDXW(CIDXW),
        .CIDX_ADDRW(CIDX_ADDRW), .CLUT_LAT(CLUT_LAT), .BG_COLR(BG)
    ) dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .dx(dx), .dy(dy),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start),
        .layer_pix(layer_pix), .layer_paint(layer_paint), .cfg(cfg_bus),
        .clut_addr(clut_addr), .clut_dout(clut_dout),
        .disp_x(disp_x), .disp_y(disp_y), .disp_hsync(disp_hsync),
        .disp_vsync(disp_vsync), .disp_de(disp_de), .disp_frame(disp_frame),
        .disp_r(disp_r), .disp_g(disp_g), .disp_b(disp_b)
    );

    always #5 clk_pix = ~clk_pix;

    always @(posedge clk_pix) begin
        clut_d1 <= clut_addr;
        clut_d2 <= clut_d1;
    end
    assign clut_dout = 15'(clut_d2);
    assign rgb       = {disp_r, disp_g, disp_b};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_pix);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] layer, input logic en, input logic tr,
                             input logic [7:0] base, input logic fs);
        cfg_bus.cfg_we     = 1'b1;
        cfg_bus.cfg_layer  = layer;
        cfg_bus.cfg_en     = en;
        cfg_bus.cfg_transp = tr;
        cfg_bus.cfg_base   = base;
        frame_start        = fs;
        step(1);
        cfg_bus.cfg_we     = 1'b0;
        frame_start        = 1'b0;
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_bus.cfg_we     = 1'b0;
        cfg_bus.cfg_layer  = '0;
        cfg_bus.cfg_en     = 1'b0;
        cfg_bus.cfg_transp = 1'b0;
        cfg_bus.cfg_base   = '0;
        #1 rst_pix = 1'b1;
        #12;
        check("rst_clut_addr", 32'(clut_addr), 32'd0);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_disp_de", 32'(disp_de), 32'd0);
        check("rst_disp_vsync", 32'(disp_vsync), 32'd0);
        check("rst_pending", 32'(cfg_bus.cfg_pending), 32'd0);
        @(posedge clk_pix);
        #1;
        rst_pix = 1'b0;

        // Single layer through the full pipeline, with changing coordinates.
        de = 1'b1; layer_paint = 2'b01; layer_pix = 8'h05;
        dx = 16'sd100; dy = 16'sd7; hsync = 1'b1;
        step(1);
        check("t1_clut_addr", 32'(clut_addr), 32'd5);
        dx = 16'sd101; dy = 16'sd8; layer_pix = 8'h06;
        step(2);
        check("t1_disp_de_early", 32'(disp_de), 32'd0);
        step(1);
        check("t1_disp_x", {16'd0, disp_x}, 32'd100);
        check("t1_disp_y", {16'd0, disp_y}, 32'd7);
        check("t1_disp_hsync", 32'(disp_hsync), 32'd1);
        check("t1_rgb", 32'(rgb), 32'd5);
        step(1);
        check("t1_disp_x_next", {16'd0, disp_x}, 32'd101);
        check("t1_rgb_next", 32'(rgb), 32'd6);

        // Two layers; enabling layer 1 keeps layer 0 in front until it is disabled.
        layer_pix = 8'h73; layer_paint = 2'b11;
        cfg_write(3'd1, 1'b1, 1'b0, 8'd0, 1'b0);
        check("t2_pending_set", 32'(cfg_bus.cfg_pending), 32'd1);
        check("t2_addr_before", 32'(clut_addr), 32'd3);
        frame_pulse();
        check("t2_pending_clr", 32'(cfg_bus.cfg_pending), 32'd0);
        check("t2_addr_l0", 32'(clut_addr), 32'd3);
        cfg_write(3'd0, 1'b0, 1'b0, 8'd0, 1'b0);
        check("t2_pending_l0", 32'(cfg_bus.cfg_pending), 32'd1);
        check("t2_addr_held", 32'(clut_addr), 32'd3);
        frame_pulse();
        check("t2_addr_l1", 32'(clut_addr), 32'd7);
        step(3);
        check("t2_disp_frame", 32'(disp_frame), 32'd1);
        step(1);
        check("t2_disp_frame_end", 32'(disp_frame), 32'd0);

        // Transparency, palette base and base wrap.
        layer_pix = 8'h90;
        cfg_write(3'd0, 1'b1, 1'b1, 8'd0, 1'b0);
        cfg_write(3'd1, 1'b1, 1'b0, 8'd16, 1'b1);
        check("t3_addr_base", 32'(clut_addr), 32'd25);
        check("t3_pending", 32'(cfg_bus.cfg_pending), 32'd0);
        layer_pix = 8'h92;
        step(1);
        check("t3_addr_l0_opaque", 32'(clut_addr), 32'd2);
        layer_pix = 8'h90;
        cfg_write(3'd1, 1'b1, 1'b0, 8'd250, 1'b1);
        check("t3_addr_wrap", 32'(clut_addr), 32'd3);

        // Out-of-range layer write is dropped; valid write waits for frame start.
        cfg_write(3'd5, 1'b1, 1'b0, 8'd100, 1'b0);
        check("t4_pending_bad", 32'(cfg_bus.cfg_pending), 32'd0);
        check("t4_addr_bad", 32'(clut_addr), 32'd3);
        frame_pulse();
        check("t4_addr_bad_frame", 32'(clut_addr), 32'd3);
        cfg_write(3'd1, 1'b1, 1'b0, 8'd40, 1'b0);
        check("t4_pending_good", 32'(cfg_bus.cfg_pending), 32'd1);
        check("t4_addr_held", 32'(clut_addr), 32'd3);
        frame_pulse();
        check("t4_pending_clr", 32'(cfg_bus.cfg_pending), 32'd0);
        check("t4_addr_new", 32'(clut_addr), 32'd49);

        // Write and frame start on the same cycle.
        layer_pix = 8'h91;
        cfg_write(3'd0, 1'b1, 1'b0, 8'd32, 1'b1);
        check("t5_addr_bypass", 32'(clut_addr), 32'd33);
        check("t5_pending", 32'(cfg_bus.cfg_pending), 32'd0);

        // Blanking, background and asynchronous reset.
        de = 1'b0;
        step(4);
        check("t6_rgb_blank", 32'(rgb), 32'd0);
        check("t6_de_blank", 32'(disp_de), 32'd0);
        de = 1'b1; layer_paint = 2'b00;
        step(1);
        check("t6_addr_none", 32'(clut_addr), 32'd0);
        step(3);
        check("t6_rgb_bg", 32'(rgb), 32'(BG));
        check("t6_de_on", 32'(disp_de), 32'd1);
        layer_paint = 2'b01;
        step(4);
        check("t6_rgb_l0", 32'(rgb), 32'd33);
        cfg_write(3'd1, 1'b0, 1'b0, 8'd1, 1'b0);
        check("t6_pending_pre_rst", 32'(cfg_bus.cfg_pending), 32'd1);
        #2 rst_pix = 1'b1;
        #1;
        check("t6_rst_clut_addr", 32'(clut_addr), 32'd0);
        check("t6_rst_rgb", 32'(rgb), 32'd0);
        check("t6_rst_disp_x", {16'd0, disp_x}, 32'd0);
        check("t6_rst_disp_de", 32'(disp_de), 32'd0);
        check("t6_rst_disp_hsync", 32'(disp_hsync), 32'd0);
        check("t6_rst_pending", 32'(cfg_bus.cfg_pending), 32'd0);
        @(posedge clk_pix);
        #1;
        rst_pix = 1'b0;
        layer_paint = 2'b11; layer_pix = 8'h73;
        step(1);
        check("t6_post_rst_l0", 32'(clut_addr), 32'd3);
        layer_paint = 2'b10;
        step(1);
        check("t6_post_rst_l1_off", 32'(clut_addr), 32'd0);
        step(3);
        check("t6_post_rst_bg", 32'(rgb), 32'(BG));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
